// File: rtl/pcie3_intx_pkg.sv
// Shared types and constants for the PCIe3 legacy INTx requester.
package pcie3_intx_pkg;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    ASSERT_WAIT   = 3'd1,
    ACTIVE        = 3'd2,
    DEASSERT_WAIT = 3'd3,
    HOLDOFF       = 3'd4
  } intx_state_e;

  localparam int HOLDOFF_CYCLES = 1;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pcie3_intx_src_latch.sv
// One interrupt source: rising-edge detect feeding a sticky status bit (set beats clear).
module pcie3_intx_src_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_i,
  input  logic clear_i,
  output logic status_o
);

  logic prev_q, arm_q, status_q;
  logic rise;

  // arm_q masks the first cycle after reset so a source already high is not taken as an edge.
  assign rise = irq_i & ~prev_q & arm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= 1'b0;
      arm_q    <= 1'b0;
      status_q <= 1'b0;
    end else begin
      prev_q   <= irq_i;
      arm_q    <= 1'b1;
      status_q <= rise | (status_q & ~clear_i);
    end
  end

  assign status_o = status_q;

endmodule

// File: rtl/pcie3_intx_request_ctrl.sv
// Legacy INTx requester: sticky maskable sources -> one INTx pin with message handshake.
// Optional m_sent watchdog enabled by defining PCIE3_INTX_TIMEOUT_EN.
module pcie3_intx_request_ctrl
  import pcie3_intx_pkg::*;
#(
  parameter int C_NUM_SOURCES       = 8,
  parameter int C_INTX_VECTOR_WIDTH = 4,
  parameter int C_INTX_PIN          = 0,
  parameter int C_PENDING_WIDTH     = 1,
  parameter int C_TIMEOUT_CYCLES    = 1024
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [C_NUM_SOURCES-1:0]       irq_in,
  input  logic [C_NUM_SOURCES-1:0]       irq_mask,
  input  logic [C_NUM_SOURCES-1:0]       irq_clear,
  output logic [C_NUM_SOURCES-1:0]       irq_status,
  output logic [C_INTX_VECTOR_WIDTH-1:0] m_intx_vector,
  input  logic                           m_sent,
  output logic [C_PENDING_WIDTH-1:0]     m_pending,
  output logic                           intx_active,
  output logic                           timeout_err,
  input  logic                           err_clear
);

  if (C_INTX_PIN < 0 || C_INTX_PIN >= C_INTX_VECTOR_WIDTH) begin : g_bad_pin
    $error("C_INTX_PIN must be below C_INTX_VECTOR_WIDTH");
  end
  if (C_NUM_SOURCES < 1 || C_NUM_SOURCES > 32) begin : g_bad_src
    $error("C_NUM_SOURCES must be 1..32");
  end

  logic [C_NUM_SOURCES-1:0] status;

  for (genvar i = 0; i < C_NUM_SOURCES; i++) begin : g_src
    pcie3_intx_src_latch u_latch (
      .clk      (aclk),
      .rst_n    (aresetn),
      .irq_i    (irq_in[i]),
      .clear_i  (irq_clear[i]),
      .status_o (status[i])
    );
  end

  intx_state_e state_q, state_d;
  logic        req_q, asserted_q, tmo;
  logic [1:0]  hold_q, hold_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:          if (req_q)          state_d = ASSERT_WAIT;
      ASSERT_WAIT:   if (m_sent || tmo)  state_d = ACTIVE;
      ACTIVE:        if (!req_q)         state_d = DEASSERT_WAIT;
      DEASSERT_WAIT: if (m_sent || tmo)  state_d = HOLDOFF;
      HOLDOFF:       if (hold_q == 2'(HOLDOFF_CYCLES - 1)) state_d = IDLE;
      default:       state_d = IDLE;
    endcase
    hold_d = (state_q == HOLDOFF && state_d == HOLDOFF) ? hold_q + 2'd1 : 2'd0;
  end

  // Output level is registered from the next state so it tracks the FSM with no extra lag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      asserted_q <= 1'b0;
      hold_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      req_q      <= |(status & ~irq_mask);
      asserted_q <= (state_d == ASSERT_WAIT) || (state_d == ACTIVE);
      hold_q     <= hold_d;
    end
  end

`ifdef PCIE3_INTX_TIMEOUT_EN
  localparam int CW = cnt_width(C_TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q;
  logic          wait_st, err_q;

  assign wait_st = (state_q == ASSERT_WAIT) || (state_q == DEASSERT_WAIT);
  // Fires on the cycle whose closing edge brings the count to C_TIMEOUT_CYCLES.
  assign tmo     = wait_st && !m_sent && (cnt_q == CW'(C_TIMEOUT_CYCLES - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_d != state_q || !wait_st) ? '0 : cnt_q + 1'b1;
      err_q <= tmo | (err_q & ~err_clear);
    end
  end

  assign timeout_err = err_q;
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear;
  assign tmo              = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  always_comb begin
    m_intx_vector             = '0;
    m_intx_vector[C_INTX_PIN] = asserted_q;
    m_pending                 = '0;
    m_pending[0]              = req_q;
  end

  assign irq_status  = status;
  assign intx_active = asserted_q;

endmodule

// File: tb/tb_pcie3_intx_request_ctrl.sv
// Directed bench for pcie3_intx_request_ctrl; define PCIE3_INTX_TIMEOUT_EN to cover the watchdog.
module tb_pcie3_intx_request_ctrl;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [7:0] irq_in, irq_mask, irq_clear, irq_status;
  logic [3:0] m_intx_vector;
  logic       m_sent, intx_active, timeout_err, err_clear;
  logic [0:0] m_pending;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 aclk = ~aclk;

  pcie3_intx_request_ctrl #(
    .C_NUM_SOURCES(8), .C_INTX_VECTOR_WIDTH(4), .C_INTX_PIN(0),
    .C_PENDING_WIDTH(1), .C_TIMEOUT_CYCLES(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .irq_in(irq_in), .irq_mask(irq_mask),
    .irq_clear(irq_clear), .irq_status(irq_status), .m_intx_vector(m_intx_vector),
    .m_sent(m_sent), .m_pending(m_pending), .intx_active(intx_active),
    .timeout_err(timeout_err), .err_clear(err_clear)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic send();
    m_sent = 1'b1; step(1); m_sent = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] m);
    irq_in = m; step(1); irq_in = 8'h00;
  endtask

  task automatic clr(input logic [7:0] m);
    irq_clear = m; step(1); irq_clear = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog no finish");
    $fatal(1);
  end

  initial begin
    aresetn = 1'b0; irq_in = '0; irq_mask = '0; irq_clear = '0;
    m_sent = 1'b0; err_clear = 1'b0;
    step(2);
    chk("rst_vec", m_intx_vector, 4'h0);
    chk("rst_status", irq_status, 8'h00);
    chk("rst_pending", m_pending, 1'b0);
    chk("rst_active", intx_active, 1'b0);
    chk("rst_err", timeout_err, 1'b0);
    aresetn = 1'b1;
    step(2);

    // single source, bit 3
    pulse(8'h08);
    chk("s1_status", irq_status, 8'h08);
    chk("s1_pend_t1", m_pending, 1'b0);
    step(1);
    chk("s1_pend_t2", m_pending, 1'b1);
    chk("s1_vec_t2", m_intx_vector, 4'h0);
    step(1);
    chk("s1_vec_t3", m_intx_vector, 4'h1);
    chk("s1_active", intx_active, 1'b1);
    step(4);
    chk("s1_no_err", timeout_err, 1'b0);
    send();
    step(1);
    clr(8'h08);
    chk("s1_clr_status", irq_status, 8'h00);
    chk("s1_clr_vec_c1", m_intx_vector, 4'h1);
    step(1);
    chk("s1_clr_pend_c2", m_pending, 1'b0);
    chk("s1_clr_vec_c2", m_intx_vector, 4'h1);
    step(1);
    chk("s1_clr_vec_c3", m_intx_vector, 4'h0);
    chk("s1_clr_active", intx_active, 1'b0);
    step(2);
    send();
    step(2);
    chk("s1_idle_vec", m_intx_vector, 4'h0);
    chk("s1_idle_status", irq_status, 8'h00);

    // masking
    irq_mask = 8'h01;
    pulse(8'h01);
    step(2);
    chk("m_status", irq_status, 8'h01);
    chk("m_vec_masked", m_intx_vector, 4'h0);
    chk("m_pend_masked", m_pending, 1'b0);
    step(3);
    chk("m_vec_masked2", m_intx_vector, 4'h0);
    irq_mask = 8'h00;
    step(1);
    chk("m_unmask_pend", m_pending, 1'b1);
    chk("m_unmask_vec1", m_intx_vector, 4'h0);
    step(1);
    chk("m_unmask_vec2", m_intx_vector, 4'h1);
    send();
    step(1);
    irq_mask = 8'h01;
    step(1);
    chk("m_remask_pend", m_pending, 1'b0);
    chk("m_remask_vec1", m_intx_vector, 4'h1);
    step(1);
    chk("m_remask_vec2", m_intx_vector, 4'h0);
    send();
    step(2);
    chk("m_sticky", irq_status, 8'h01);
    clr(8'h01);
    irq_mask = 8'h00;
    step(3);
    chk("m_done_vec", m_intx_vector, 4'h0);
    chk("m_done_pend", m_pending, 1'b0);

    // overlap of sources 1 and 5
    pulse(8'h22);
    step(2);
    chk("ov_vec", m_intx_vector, 4'h1);
    chk("ov_status", irq_status, 8'h22);
    send();
    step(1);
    clr(8'h02);
    step(2);
    chk("ov_keep_vec", m_intx_vector, 4'h1);
    chk("ov_keep_status", irq_status, 8'h20);
    chk("ov_keep_pend", m_pending, 1'b1);
    clr(8'h20);
    step(1);
    chk("ov_last_pend", m_pending, 1'b0);
    chk("ov_last_vec1", m_intx_vector, 4'h1);
    step(1);
    chk("ov_last_vec2", m_intx_vector, 4'h0);
    send();
    step(2);

    // re-raise while the deassert message is outstanding
    pulse(8'h04);
    step(2);
    chk("rr_vec_on", m_intx_vector, 4'h1);
    send();
    step(1);
    clr(8'h04);
    step(2);
    chk("rr_deassert", m_intx_vector, 4'h0);
    for (int k = 1; k <= 7; k++) begin
      step(1);
      if (k == 1) irq_in = 8'h40;
      if (k == 2) irq_in = 8'h00;
      if (k == 5) m_sent = 1'b1;
      if (k == 6) m_sent = 1'b0;
      chk($sformatf("rr_gap_%0d", k), m_intx_vector, 4'h0);
    end
    step(1);
    chk("rr_reassert", m_intx_vector, 4'h1);
    send();
    step(1);
    clr(8'h40);
    step(3);
    chk("rr_off", m_intx_vector, 4'h0);
    send();
    step(2);

`ifdef PCIE3_INTX_TIMEOUT_EN
    pulse(8'h10);
    step(2);
    chk("to_vec", m_intx_vector, 4'h1);
    step(15);
    chk("to_err_early", timeout_err, 1'b0);
    step(1);
    chk("to_err_set", timeout_err, 1'b1);
    chk("to_active", intx_active, 1'b1);
    clr(8'h10);
    step(2);
    chk("to_in_active", m_intx_vector, 4'h0);
    err_clear = 1'b1; step(1); err_clear = 1'b0;
    chk("to_err_clr", timeout_err, 1'b0);
    send();
    step(2);
`endif

    // async reset while ACTIVE, source held high across it
    irq_in = 8'h80;
    step(3);
    chk("ar_vec_on", m_intx_vector, 4'h1);
    send();
    step(2);
    #2 aresetn = 1'b0;
    #1;
    chk("ar_vec", m_intx_vector, 4'h0);
    chk("ar_active", intx_active, 1'b0);
    chk("ar_pend", m_pending, 1'b0);
    chk("ar_status", irq_status, 8'h00);
    step(1);
    aresetn = 1'b1;
    step(5);
    chk("ar_held_vec", m_intx_vector, 4'h0);
    chk("ar_held_status", irq_status, 8'h00);
    chk("ar_held_pend", m_pending, 1'b0);
    irq_in = 8'h00;
    step(1);
    pulse(8'h80);
    chk("ar_new_status", irq_status, 8'h80);
    step(2);
    chk("ar_new_vec", m_intx_vector, 4'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pcie3_intx_request_ctrl.md
# pcie3_intx_request_ctrl

Legacy INTx interrupt requester that feeds the PCIe3 configuration interrupt interface. It collects up to C_NUM_SOURCES user interrupt sources into sticky, maskable status bits and drives one INTx vector bit. Each Assert_INTx and Deassert_INTx message it requests is held until the core returns `m_sent`. It sits directly upstream of the pcie3_cfg_interrupt wirethrough stage and connects to its S side.

## Interface
- C_NUM_SOURCES, 8: number of user interrupt sources (1..32).
- C_INTX_VECTOR_WIDTH, 4: width of `m_intx_vector` (INTA..INTD).
- C_INTX_PIN, 0: vector bit used; elaboration error if not < C_INTX_VECTOR_WIDTH.
- C_PENDING_WIDTH, 1: width of `m_pending`.
- C_TIMEOUT_CYCLES, 1024: `m_sent` wait limit; used only with PCIE3_INTX_TIMEOUT_EN.
- One clock; reset is asynchronous and active-low: `aclk`, `aresetn`.
- aclk  in  1  clock.
- aresetn  in  1  async active-low reset.
- irq_in  in  C_NUM_SOURCES  user interrupt sources, synchronous to aclk, edge-detected.
- irq_mask  in  C_NUM_SOURCES  1 = source excluded from request.
- irq_clear  in  C_NUM_SOURCES  write-1-to-clear pulse for status.
- irq_status  out  C_NUM_SOURCES  sticky status, unmasked.
- m_intx_vector  out  C_INTX_VECTOR_WIDTH  to core; only bit C_INTX_PIN is ever driven to 1.
- m_sent  in  1  core pulse: message sent.
- m_pending  out  C_PENDING_WIDTH  bit 0 = registered request; other bits 0.
- intx_active  out  1  high in ASSERT_WAIT and ACTIVE.
- timeout_err  out  1  sticky; cleared by `err_clear`.
- err_clear  in  1  clears `timeout_err`.

## Operation
- Status: `irq_status[i]` sets on a rising edge of `irq_in[i]` (the previous-cycle copy is registered). It clears on `irq_clear[i]`. When set and clear occur in the same cycle, set wins.
- Request: req = |(irq_status & ~irq_mask), registered into req_q.
- FSM states: IDLE, ASSERT_WAIT, ACTIVE, DEASSERT_WAIT, HOLDOFF.
- IDLE: intx bit 0. Moves to ASSERT_WAIT when req_q=1.
- ASSERT_WAIT: intx bit 1. Moves to ACTIVE when `m_sent`=1.
- ACTIVE: intx bit 1. Moves to DEASSERT_WAIT when req_q=0, whether from clear or from mask.
- DEASSERT_WAIT: intx bit 0. Moves to HOLDOFF on `m_sent`. A new request is ignored until the deassert message completes.
- HOLDOFF: one cycle, then IDLE. This guarantees at least 2 cycles of deasserted level between messages.
- `m_sent` is ignored in IDLE, ACTIVE and HOLDOFF.
- Reset values: all outputs 0, state IDLE, status 0, previous-cycle copy of irq_in 0. Reset mid-message abandons the handshake with no deassert sent, because the core shares the same reset.

## Timing
- Source rising edge in cycle t: status=1 at t+1, req_q=1 at t+2, `m_intx_vector[C_INTX_PIN]`=1 at t+3.
- `m_pending[0]` equals req_q and has the same latency.
- `m_sent` in cycle s while in ASSERT_WAIT: state ACTIVE at s+1.
- Clear in cycle c, with no other active sources: req_q=0 at c+2, intx bit 0 at c+3.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- PCIE3_INTX_TIMEOUT_EN defined:
  - A counter of width $clog2(C_TIMEOUT_CYCLES+1) runs in ASSERT_WAIT and in DEASSERT_WAIT, and resets on every state change.
  - If it reaches C_TIMEOUT_CYCLES with no `m_sent`, `timeout_err` sets and the FSM advances as if `m_sent` had arrived.
  - When `err_clear` and a new timeout occur in the same cycle, set wins.
- Undefined: no counter is built, `timeout_err` is tied to 0, and the FSM waits on `m_sent` indefinitely.

## Structure
- Package pcie3_intx_pkg holds:
  - the state enum (IDLE, ASSERT_WAIT, ACTIVE, DEASSERT_WAIT, HOLDOFF);
  - localparam HOLDOFF_CYCLES = 1;
  - a function computing the counter width.
- Sub-module pcie3_intx_src_latch holds the per-source edge detect and the sticky set/clear bit. It is instantiated with a generate loop over C_NUM_SOURCES.
- The top level holds the request reduction, the FSM, the output registers and the optional timeout counter.

## Test plan
- Single source: pulse `irq_in[3]`, then `m_sent` 4 cycles after assert.
  - Expect intx bit 0 high 3 cycles after the edge, and `m_pending`=1.
  - Then clear bit 3 and return `m_sent` 2 cycles after deassert: intx low, FSM back to IDLE after HOLDOFF, `irq_status`=0.
- Masking:
  - Set `irq_mask[0]`=1 and pulse `irq_in[0]`: `irq_status[0]`=1 and intx stays 0.
  - Unmask: intx rises 2 cycles later.
- Overlap: sources 1 and 5 both active, then clear 1 only.
  - Expect intx to stay 1.
  - Clearing 5 then starts the deassert.
- Re-raise during DEASSERT_WAIT: new source edge arrives before `m_sent`.
  - Deassert must complete first, then HOLDOFF, then a fresh assert.
  - The bench checks a minimum 2-cycle low gap.
- Timeout (PCIE3_INTX_TIMEOUT_EN, C_TIMEOUT_CYCLES=16): never drive `m_sent`.
  - Expect `timeout_err`=1 16 cycles after the assert, and the FSM in ACTIVE.
  - `err_clear` returns it to 0.
- Async reset asserted in ACTIVE: all outputs are 0 immediately. After release, a pre-existing high `irq_in` does not cause an assert until a new edge.
